// File: rtl/async_fifo_wr_ctrl_pkg.sv
// Shared defaults and helpers for the dual-clock FIFO write-side controller.
// Holds the default geometry, the synchroniser depth and the binary-to-gray converter.
package async_fifo_wr_ctrl_pkg;

  localparam int DEF_ASIZE    = 4;
  localparam int DEF_AFULL_TH = 12;
  localparam int SYNC_STAGES  = 2;
  localparam int MAX_PW       = 13;

  function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-client / RAM / read-pointer bundle for the FIFO write-side controller.
// master = write client side, slave = controller side.
interface async_fifo_wr_ctrl_if
  import async_fifo_wr_ctrl_pkg::*;
#(
  parameter int ASIZE = DEF_ASIZE
);

  logic             wr_en;
  logic             ovf_clr;
  logic [ASIZE:0]   rd_gptr_async;
  logic [ASIZE-1:0] wr_addr;
  logic             wr_ram_en;
  logic [ASIZE:0]   wr_gptr;
  logic             wr_full;
  logic             wr_afull;
  logic [ASIZE:0]   wr_cnt;
  logic             wr_ovf;

  modport master (
    output wr_en, ovf_clr, rd_gptr_async,
    input  wr_addr, wr_ram_en, wr_gptr, wr_full, wr_afull, wr_cnt, wr_ovf
  );

  modport slave (
    input  wr_en, ovf_clr, rd_gptr_async,
    output wr_addr, wr_ram_en, wr_gptr, wr_full, wr_afull, wr_cnt, wr_ovf
  );

endinterface

// File: rtl/async_fifo_wr_ctrl_gray_to_binary.sv
// Gray-to-binary converter: each binary bit is the XOR of all gray bits from the MSB down to it.
module gray_to_binary #(
  parameter int DSIZE = 5
) (
  input  logic [DSIZE-1:0] i_gray,
  output logic [DSIZE-1:0] o_bin
);

  for (genvar i = 0; i < DSIZE; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[DSIZE-1:i];
  end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain pointer and flag controller for a dual-clock FIFO: binary/gray write
// pointer, read-pointer synchroniser, registered full, fill count, almost-full and sticky overflow.
module async_fifo_wr_ctrl
  import async_fifo_wr_ctrl_pkg::*;
#(
  parameter int ASIZE    = DEF_ASIZE,
  parameter int AFULL_TH = DEF_AFULL_TH
) (
  input  logic               clk,
  input  logic               rst_n,
  async_fifo_wr_ctrl_if.slave bus
);

  localparam int            PW        = ASIZE + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_TH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_gptr;
  logic          r_full;
  logic          r_ovf;
  logic [PW-1:0] r_rq_p [SYNC_STAGES];

  logic          w_wr_acc;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_gnext;
  logic [PW-1:0] w_rq_sync;
  logic [PW-1:0] w_rq_full;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_cnt;

  assign w_wr_acc    = bus.wr_en & ~r_full;
  assign w_wbin_next = r_wbin + PW'(w_wr_acc);
  assign w_gnext     = PW'(bin2gray(MAX_PW'(w_wbin_next)));

  // Full when the next write pointer sits exactly one lap ahead of the synchronised read pointer.
  assign w_rq_sync = r_rq_p[SYNC_STAGES-1];
  assign w_rq_full = {~w_rq_sync[PW-1:PW-2], w_rq_sync[PW-3:0]};

  gray_to_binary #(.DSIZE(PW)) u_g2b (
    .i_gray (w_rq_sync),
    .o_bin  (w_rbin)
  );

  assign w_cnt = r_wbin - w_rbin;

  // Stage p0 -> p1: pointer, full and overflow state, all updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin <= '0;
      r_gptr <= '0;
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_wbin <= w_wbin_next;
      r_gptr <= w_gnext;
      r_full <= (w_gnext == w_rq_full);
      if (bus.wr_en && r_full) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Read-pointer synchroniser stages; only the last stage is observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_rq_p[i] <= '0;
      end
    end else begin
      r_rq_p[0] <= bus.rd_gptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_rq_p[i] <= r_rq_p[i-1];
      end
    end
  end

  assign bus.wr_addr   = r_wbin[ASIZE-1:0];
  assign bus.wr_ram_en = w_wr_acc;
  assign bus.wr_gptr   = r_gptr;
  assign bus.wr_full   = r_full;
  assign bus.wr_afull  = (w_cnt >= AFULL_LVL);
  assign bus.wr_cnt    = w_cnt;
  assign bus.wr_ovf    = r_ovf;

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for a dual-clock FIFO; runs entirely in the write clock domain.
- Keeps the binary write pointer and generates the RAM write address.
- Produces the gray-coded write pointer that is exported to the read domain.
- Synchronises the gray-coded read pointer in, then derives full, almost-full, fill count and overflow.
- Sits between the write client and the dual-port RAM; its read-side counterpart is a separate block.

Parameters:
ASIZE, 4, RAM address width; FIFO depth = 2**ASIZE; legal range 2..12.
AFULL_TH, 12, fill level at or above which wr_afull asserts; legal range 1..2**ASIZE.

Ports:
clk  input  1  write-domain clock.
rst_n  input  1  asynchronous active-low reset.
wr_en  input  1  write request from client.
ovf_clr  input  1  clears sticky overflow flag.
rd_gptr_async  input  ASIZE+1  gray read pointer from read domain (asynchronous to clk).
wr_addr  output  ASIZE  RAM write address for the current request.
wr_ram_en  output  1  RAM write strobe (accepted write).
wr_gptr  output  ASIZE+1  registered gray write pointer, to read-domain synchroniser.
wr_full  output  1  FIFO full (registered).
wr_afull  output  1  fill count >= AFULL_TH.
wr_cnt  output  ASIZE+1  write-side fill count (conservative).
wr_ovf  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (rst_n low, asynchronous assert; release synchronous to clk edge externally):
  - wbin, wr_gptr and both synchroniser stages = 0.
  - wr_full = 0, wr_ovf = 0, so wr_cnt = 0, wr_afull = 0 (0 >= AFULL_TH is false for AFULL_TH >= 1).
- Accept rule: wr_ram_en = wr_en & ~wr_full (combinational).
  - wr_addr = wbin[ASIZE-1:0] (combinational from register) and is the address for the accepted word in that cycle.
- On each clk edge:
  - wbin_next = wbin + wr_ram_en, modulo 2**(ASIZE+1).
  - wbin <= wbin_next.
  - wr_gptr <= (wbin_next >> 1) ^ wbin_next.
  - Single-bit gray change per increment is mandatory.
- Read-pointer synchronisation:
  - Two-flop synchroniser: rq1 <= rd_gptr_async; rq2 <= rq1.
  - Only rq2 is used internally; latency is 2 clk cycles.
- Full:
  - wr_full <= (gnext == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]}), where gnext is the gray of wbin_next.
  - wr_full is registered and updates at the same edge as the pointer.
  - A write accepted into the last free entry asserts wr_full on the following cycle with no gap.
  - Deassertion occurs only after a read-pointer change has passed the 2-flop synchroniser (pessimistic; no overflow possible).
- Count:
  - rbin = gray_to_binary(rq2).
  - wr_cnt = wbin - rbin, modulo 2**(ASIZE+1); a full FIFO reads as 2**ASIZE.
  - wr_afull = (wr_cnt >= AFULL_TH).
  - Both are combinational from registers.
- Overflow:
  - wr_ovf <= 1 when wr_en & wr_full.
  - Cleared by ovf_clr at the next edge.
  - Simultaneous set and clear: set wins.
  - A write while full is dropped: pointer unchanged, wr_ram_en = 0.
- Wrap-around: wbin rolls from 2**(ASIZE+1)-1 to 0; the extra MSB distinguishes full from empty.
- Reset mid-operation: all state clears immediately; the read side must be reset concurrently (system requirement, not checked here).

Decomposition:
- Shared header fifo_defs.vh: default ASIZE, AFULL_TH, and the synchroniser stage count (2).
- Reuse the existing common binary_to_gray converter for gnext.
- New sub-module gray_to_binary (DSIZE parameter; prefix-XOR from MSB) for rbin, placed in common/ beside the existing converter.

Test Plan:
1. Reset, then idle with rd_gptr_async=0 -> wr_gptr=0, wr_full=0, wr_cnt=0, wr_afull=0, wr_ovf=0.
2. ASIZE=4, rd_gptr_async held 0, wr_en high 16 cycles:
   - wr_addr steps 0..15, wr_gptr sequence 0,1,3,2,6,...
   - wr_afull asserts on the cycle after the 12th accepted write.
   - After the 16th write: wr_full=1, wr_cnt=16, wr_gptr=5'b11000.
3. Keep wr_en high while full -> wr_ram_en=0, wbin holds 16, wr_ovf=1 next cycle; pulse ovf_clr with wr_en=0 -> wr_ovf=0.
4. From full, drive rd_gptr_async=gray(4)=5'b00110 ->
   - wr_full stays 1 for 2 edges.
   - wr_full clears on the 3rd edge and wr_cnt=12.
   - The next write is accepted at wr_addr=0.
5. Run continuous writes and reads across the 31->0 pointer wrap (rd_gptr_async advanced in gray, one bit at a time) -> no false full, wr_cnt never exceeds 16, wr_gptr changes exactly 1 bit per accepted write.
6. Assert rst_n low mid-burst between clock edges -> all outputs zero immediately; writes resume from wr_addr=0 after release.
